// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing control.
package pipe_ctrl_pkg;

  // Register-address width, matches the Rd field carried in the pipeline registers.
  localparam int RADDR_W = 6;

  // Sequencer state encoding.
  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_MDU_WAIT = 1'b1
  } state_e;

  // Instruction word loaded into IF/ID when it is flushed (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Control bundle driven into PC, IF/ID, ID/EX and the MDU.
  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_flush;
    logic mdu_start;
  } ctrl_t;

  // All controls inactive.
  localparam ctrl_t CTRL_IDLE = '0;

  // Freeze PC and IF/ID, inject a bubble into ID/EX.
  localparam ctrl_t CTRL_HOLD = '{
    pc_stall:    1'b1,
    if_id_stall: 1'b1,
    if_id_flush: 1'b0,
    id_ex_flush: 1'b1,
    mdu_start:   1'b0
  };

endpackage

// File: rtl/hazard_cmp.sv
// Load-use hazard detector: the instruction in EX is a load whose destination
// is a source actually read by the instruction in ID. x0 never hazards.
// Purely combinational so it can be reused by forwarding-select logic.
module hazard_cmp
  import pipe_ctrl_pkg::*;
#(
  parameter int RADDR_W = pipe_ctrl_pkg::RADDR_W
) (
  input  logic [RADDR_W-1:0] rs1_id,
  input  logic [RADDR_W-1:0] rs2_id,
  input  logic               rs1_used_id,
  input  logic               rs2_used_id,
  input  logic [RADDR_W-1:0] rd_ex,
  input  logic               reg_wr_ex,
  input  logic               mem_to_reg_ex,
  output logic               lu_hz
);

  logic ex_load_wr;
  logic rs1_hit;
  logic rs2_hit;

  // Compare both source operands against the loading destination.
  always_comb begin
    ex_load_wr = mem_to_reg_ex & reg_wr_ex & (rd_ex != '0);
    rs1_hit    = rs1_used_id & (rs1_id == rd_ex);
    rs2_hit    = rs2_used_id & (rs2_id == rd_ex);
    lu_hz      = ex_load_wr & (rs1_hit | rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: load-use stalls, branch squashes and the
// multiply/divide unit start/done handshake with a watchdog.
//
// MDU handshake: MDU_start is a single-cycle launch pulse issued from RUN;
// the MDU answers with a single-cycle MDU_done pulse at any later cycle. There
// is no back-pressure. A done seen outside MDU_WAIT is stale and is dropped;
// if no done arrives within MDU_TIMEOUT stall cycles the wait is abandoned and
// MDU_err latches until Reset.
//
// Control outputs are combinational from state and current inputs so they are
// settled before the pipeline registers capture on the same edge.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RADDR_W     = pipe_ctrl_pkg::RADDR_W,
  parameter int MDU_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic               CLK,
  input  logic               Reset,
  input  logic [RADDR_W-1:0] rs1_ID,
  input  logic [RADDR_W-1:0] rs2_ID,
  input  logic               rs1_used_ID,
  input  logic               rs2_used_ID,
  input  logic               MDU_req_ID,
  input  logic [RADDR_W-1:0] Rd_EX,
  input  logic               RegWr_EX,
  input  logic               MemtoReg_EX,
  input  logic               Taken_EX,
  input  logic               MDU_done,
  output logic               PC_stall,
  output logic               IF_ID_stall,
  output logic               IF_ID_flush,
  output logic               ID_EX_flush,
  output logic               MDU_start,
  output logic               MDU_err,
  output logic [CNT_W-1:0]   Stall_cnt,
  output logic               dbg_state
);

  localparam int WAIT_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MDU_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               mdu_err_q, mdu_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  ctrl_t              ctrl;
  logic               lu_hz;

  hazard_cmp #(
    .RADDR_W (RADDR_W)
  ) u_hazard_cmp (
    .rs1_id        (rs1_ID),
    .rs2_id        (rs2_ID),
    .rs1_used_id   (rs1_used_ID),
    .rs2_used_id   (rs2_used_ID),
    .rd_ex         (Rd_EX),
    .reg_wr_ex     (RegWr_EX),
    .mem_to_reg_ex (MemtoReg_EX),
    .lu_hz         (lu_hz)
  );

  // Next-state and control decode; branch squash outranks load-use, which outranks MDU launch.
  always_comb begin
    ctrl      = CTRL_IDLE;
    state_d   = state_q;
    wait_d    = wait_q;
    mdu_err_d = mdu_err_q;
    case (state_q)
      ST_RUN: begin
        if (Taken_EX) begin
          // The ID instruction is on the wrong path, so it must not launch the MDU.
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
        end else if (lu_hz) begin
          // One bubble; next cycle the bubble sits in EX and the hazard is gone.
          ctrl = CTRL_HOLD;
        end else if (MDU_req_ID) begin
          ctrl           = CTRL_HOLD;
          ctrl.mdu_start = 1'b1;
          wait_d         = '0;
          state_d        = ST_MDU_WAIT;
        end
      end
      ST_MDU_WAIT: begin
        // EX holds only bubbles here, so branches and load-use cannot occur.
        if (MDU_done) begin
          state_d = ST_RUN;
        end else if (wait_q == WAIT_LAST) begin
          mdu_err_d = 1'b1;
          state_d   = ST_RUN;
        end else begin
          ctrl   = CTRL_HOLD;
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
    // Nothing may leak to the pipeline while reset is held.
    if (Reset) begin
      ctrl = CTRL_IDLE;
    end
  end

  // Saturating count of stalled cycles.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (ctrl.pc_stall && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, watchdog, error flag and counter registers.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_RUN;
      wait_q      <= '0;
      mdu_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mdu_err_q   <= mdu_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign PC_stall    = ctrl.pc_stall;
  assign IF_ID_stall = ctrl.if_id_stall;
  assign IF_ID_flush = ctrl.if_id_flush;
  assign ID_EX_flush = ctrl.id_ex_flush;
  assign MDU_start   = ctrl.mdu_start;
  assign MDU_err     = mdu_err_q;
  assign Stall_cnt   = stall_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a table of single-cycle RUN vectors plus
// hand-written multi-cycle sequences. Two instances share the stimulus: "a"
// with the default watchdog and "w" with MDU_TIMEOUT=8.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int CNT_W = 32;
  // Expected control words: {PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush, MDU_start}
  localparam logic [4:0] E_IDLE  = 5'b00000;
  localparam logic [4:0] E_HOLD  = 5'b11010;
  localparam logic [4:0] E_FLUSH = 5'b00110;
  localparam logic [4:0] E_START = 5'b11011;

  typedef struct packed {
    logic [RADDR_W-1:0] rs1;
    logic [RADDR_W-1:0] rs2;
    logic               u1;
    logic               u2;
    logic               req;
    logic [RADDR_W-1:0] rd;
    logic               wr;
    logic               ld;
    logic               tk;
    logic               dn;
  } in_t;

  typedef struct {
    in_t        in;
    logic [4:0] exp;
  } vec_t;

  logic               CLK = 1'b0;
  logic               Reset;
  logic [RADDR_W-1:0] rs1_ID, rs2_ID, Rd_EX;
  logic               rs1_used_ID, rs2_used_ID, MDU_req_ID;
  logic               RegWr_EX, MemtoReg_EX, Taken_EX, MDU_done;

  logic               PC_stall_a, IF_ID_stall_a, IF_ID_flush_a, ID_EX_flush_a, MDU_start_a, MDU_err_a, dbg_state_a;
  logic [CNT_W-1:0]   Stall_cnt_a;
  logic               PC_stall_w, IF_ID_stall_w, IF_ID_flush_w, ID_EX_flush_w, MDU_start_w, MDU_err_w, dbg_state_w;
  logic [CNT_W-1:0]   Stall_cnt_w;
  logic [4:0]         ctrl_a, ctrl_w;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned exp_cnt_a = 0;
  int unsigned exp_cnt_w = 0;
  logic [4:0]  exp_q[$];
  vec_t        tbl[13];
  in_t         idle_in;

  assign ctrl_a = {PC_stall_a, IF_ID_stall_a, IF_ID_flush_a, ID_EX_flush_a, MDU_start_a};
  assign ctrl_w = {PC_stall_w, IF_ID_stall_w, IF_ID_flush_w, ID_EX_flush_w, MDU_start_w};

  pipe_hazard_ctrl #(.RADDR_W(RADDR_W), .MDU_TIMEOUT(64), .CNT_W(CNT_W)) dut_a (
    .CLK(CLK), .Reset(Reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .MDU_req_ID(MDU_req_ID),
    .Rd_EX(Rd_EX), .RegWr_EX(RegWr_EX), .MemtoReg_EX(MemtoReg_EX), .Taken_EX(Taken_EX),
    .MDU_done(MDU_done), .PC_stall(PC_stall_a), .IF_ID_stall(IF_ID_stall_a),
    .IF_ID_flush(IF_ID_flush_a), .ID_EX_flush(ID_EX_flush_a), .MDU_start(MDU_start_a),
    .MDU_err(MDU_err_a), .Stall_cnt(Stall_cnt_a), .dbg_state(dbg_state_a)
  );

  pipe_hazard_ctrl #(.RADDR_W(RADDR_W), .MDU_TIMEOUT(8), .CNT_W(CNT_W)) dut_w (
    .CLK(CLK), .Reset(Reset), .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
    .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID), .MDU_req_ID(MDU_req_ID),
    .Rd_EX(Rd_EX), .RegWr_EX(RegWr_EX), .MemtoReg_EX(MemtoReg_EX), .Taken_EX(Taken_EX),
    .MDU_done(MDU_done), .PC_stall(PC_stall_w), .IF_ID_stall(IF_ID_stall_w),
    .IF_ID_flush(IF_ID_flush_w), .ID_EX_flush(ID_EX_flush_w), .MDU_start(MDU_start_w),
    .MDU_err(MDU_err_w), .Stall_cnt(Stall_cnt_w), .dbg_state(dbg_state_w)
  );

  // Clock and global time limit.
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "time limit");
  end

  function automatic in_t mk_in(input int rs1, input int rs2, input bit u1, input bit u2,
                                input bit req, input int rd, input bit wr, input bit ld,
                                input bit tk, input bit dn);
    in_t v;
    v.rs1 = RADDR_W'(rs1); v.rs2 = RADDR_W'(rs2); v.u1 = u1; v.u2 = u2; v.req = req;
    v.rd  = RADDR_W'(rd);  v.wr  = wr; v.ld = ld; v.tk = tk; v.dn = dn;
    return v;
  endfunction

  task automatic apply(input in_t v);
    rs1_ID = v.rs1; rs2_ID = v.rs2; rs1_used_ID = v.u1; rs2_used_ID = v.u2;
    MDU_req_ID = v.req; Rd_EX = v.rd; RegWr_EX = v.wr; MemtoReg_EX = v.ld;
    Taken_EX = v.tk; MDU_done = v.dn;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive at negedge, compare controls 1 ns later, well before the posedge.
  task automatic step(input in_t v, input logic [4:0] exp_a, input logic [4:0] exp_w,
                      input bit chk_a, input bit chk_w, input string tag);
    @(negedge CLK);
    apply(v);
    #1;
    if (chk_a) begin
      exp_q.push_back(exp_a);
      chk({tag, ".ctrl_a"}, ctrl_a, exp_q.pop_front());
      exp_cnt_a += exp_a[4];
    end
    if (chk_w) begin
      exp_q.push_back(exp_w);
      chk({tag, ".ctrl_w"}, ctrl_w, exp_q.pop_front());
      exp_cnt_w += exp_w[4];
    end
  endtask

  // Pulse reset between edges with hazard-inducing inputs present; outputs must be 0.
  task automatic reset_both(input string tag);
    @(negedge CLK);
    apply(mk_in(5, 5, 1, 1, 1, 5, 1, 1, 0, 0));
    Reset = 1'b1;
    #1;
    chk({tag, ".rst_ctrl_a"}, ctrl_a, E_IDLE);
    chk({tag, ".rst_ctrl_w"}, ctrl_w, E_IDLE);
    chk({tag, ".rst_err_a"}, MDU_err_a, 0);
    chk({tag, ".rst_err_w"}, MDU_err_w, 0);
    chk({tag, ".rst_cnt_a"}, Stall_cnt_a, 0);
    chk({tag, ".rst_state_a"}, dbg_state_a, ST_RUN);
    apply(idle_in);
    #1;
    Reset = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_w = 0;
  endtask

  task automatic chk_state_next(input string tag, input logic exp_a, input bit use_w, input logic exp_w);
    @(posedge CLK);
    #1;
    chk({tag, ".state_a"}, dbg_state_a, exp_a);
    if (use_w) chk({tag, ".state_w"}, dbg_state_w, exp_w);
  endtask

  initial begin
    idle_in = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    Reset = 1'b1;
    apply(idle_in);

    //                  rs1 rs2 u1 u2 req rd  wr ld tk dn
    tbl[0]  = '{mk_in(1,  2,  1, 1, 0,  3,  1, 1, 0, 0), E_IDLE};   // no match
    tbl[1]  = '{mk_in(5,  2,  1, 1, 0,  5,  1, 1, 0, 0), E_HOLD};   // rs1 load-use
    tbl[2]  = '{mk_in(1,  7,  1, 1, 0,  7,  1, 1, 0, 0), E_HOLD};   // rs2 load-use
    tbl[3]  = '{mk_in(0,  0,  1, 1, 0,  0,  1, 1, 0, 0), E_IDLE};   // x0 destination
    tbl[4]  = '{mk_in(1,  9,  1, 0, 0,  9,  1, 1, 0, 0), E_IDLE};   // rs2 match, unused
    tbl[5]  = '{mk_in(9,  1,  0, 1, 0,  9,  1, 1, 0, 0), E_IDLE};   // rs1 match, unused
    tbl[6]  = '{mk_in(5,  2,  1, 1, 0,  5,  1, 0, 0, 0), E_IDLE};   // not a load
    tbl[7]  = '{mk_in(5,  2,  1, 1, 0,  5,  0, 1, 0, 0), E_IDLE};   // no register write
    tbl[8]  = '{mk_in(5,  2,  1, 1, 1,  5,  1, 1, 1, 0), E_FLUSH};  // taken beats lu and MDU
    tbl[9]  = '{mk_in(1,  2,  1, 1, 0,  3,  0, 0, 1, 0), E_FLUSH};  // plain taken
    tbl[10] = '{mk_in(1,  2,  1, 1, 0,  3,  0, 0, 0, 1), E_IDLE};   // stray done in RUN
    tbl[11] = '{mk_in(63, 4,  1, 1, 0,  63, 1, 1, 0, 0), E_HOLD};   // highest register
    tbl[12] = '{mk_in(5,  5,  1, 1, 1,  5,  1, 1, 0, 0), E_HOLD};   // lu beats MDU launch

    // Power-on reset
    @(negedge CLK);
    #1;
    chk("por.ctrl_a", ctrl_a, E_IDLE);
    chk("por.state_a", dbg_state_a, ST_RUN);
    chk("por.cnt_a", Stall_cnt_a, 0);
    reset_both("por");

    // Table-driven single-cycle RUN vectors; every one leaves the FSM in RUN
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].in, tbl[i].exp, tbl[i].exp, 1, 1, $sformatf("vec%0d", i));
      chk_state_next($sformatf("vec%0d", i), ST_RUN, 1, ST_RUN);
    end
    @(negedge CLK);
    chk("table.cnt_a", Stall_cnt_a, 64'(exp_cnt_a));
    chk("table.cnt_w", Stall_cnt_w, 64'(exp_cnt_w));

    // Load-use: one bubble, then the bubble in EX clears the hazard
    reset_both("lu");
    step(mk_in(5, 2, 1, 0, 0, 5, 1, 1, 0, 0), E_HOLD, E_HOLD, 1, 1, "lu.c0");
    step(mk_in(5, 2, 1, 0, 0, 0, 0, 0, 0, 0), E_IDLE, E_IDLE, 1, 1, "lu.c1");
    @(negedge CLK);
    chk("lu.cnt_a", Stall_cnt_a, 1);

    // MDU handshake on instance a: start, 10 wait cycles, done
    reset_both("mdu");
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_START, E_START, 1, 0, "mdu.start");
    chk_state_next("mdu.start", ST_MDU_WAIT, 0, ST_RUN);
    for (int i = 0; i < 10; i++) begin
      // Taken and a load-use pattern during the wait must be ignored
      step(mk_in(5, 2, 1, 1, 1, 5, 1, 1, (i == 4), 0), E_HOLD, E_HOLD, 1, 0,
           $sformatf("mdu.wait%0d", i));
    end
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 1), E_IDLE, E_IDLE, 1, 0, "mdu.done");
    chk_state_next("mdu.done", ST_RUN, 0, ST_RUN);
    chk("mdu.cnt_a", Stall_cnt_a, 11);
    chk("mdu.err_a", MDU_err_a, 0);
    step(idle_in, E_IDLE, E_IDLE, 1, 0, "mdu.after");

    // Watchdog on instance w (MDU_TIMEOUT=8): 8 stall cycles then abort
    reset_both("wd");
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_START, E_START, 0, 1, "wd.start");
    for (int i = 0; i < 7; i++) begin
      step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_HOLD, E_HOLD, 0, 1, $sformatf("wd.wait%0d", i));
    end
    step(idle_in, E_IDLE, E_IDLE, 0, 1, "wd.abort");
    chk("wd.err_before", MDU_err_w, 0);
    chk_state_next("wd.abort", ST_MDU_WAIT, 1, ST_RUN);
    chk("wd.err_set", MDU_err_w, 1);
    chk("wd.cnt_w", Stall_cnt_w, 8);
    // A later normal MDU operation completes and the error flag stays set
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_START, E_START, 0, 1, "wd.op_start");
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_HOLD, E_HOLD, 0, 1, "wd.op_w0");
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_HOLD, E_HOLD, 0, 1, "wd.op_w1");
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 1), E_IDLE, E_IDLE, 0, 1, "wd.op_done");
    chk_state_next("wd.op_done", ST_RUN, 1, ST_RUN);
    chk("wd.err_sticky", MDU_err_w, 1);
    chk("wd.cnt_w2", Stall_cnt_w, 64'(exp_cnt_w));
    chk("wd.err_a", MDU_err_a, 0);

    // Async reset in the middle of MDU_WAIT
    reset_both("ar");
    step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_START, E_START, 1, 1, "ar.start");
    for (int i = 0; i < 3; i++) begin
      step(mk_in(1, 2, 1, 1, 1, 0, 0, 0, 0, 0), E_HOLD, E_HOLD, 1, 1, $sformatf("ar.wait%0d", i));
    end
    #1;
    Reset = 1'b1;
    #1;
    chk("ar.ctrl_a", ctrl_a, E_IDLE);
    chk("ar.ctrl_w", ctrl_w, E_IDLE);
    chk("ar.state_a", dbg_state_a, ST_RUN);
    chk("ar.cnt_a", Stall_cnt_a, 0);
    apply(idle_in);
    #1;
    Reset = 1'b0;
    exp_cnt_a = 0;
    exp_cnt_w = 0;
    step(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1), E_IDLE, E_IDLE, 1, 1, "ar.stray_done");
    chk_state_next("ar.stray_done", ST_RUN, 1, ST_RUN);
    step(idle_in, E_IDLE, E_IDLE, 1, 1, "ar.idle");
    chk("ar.cnt_a2", Stall_cnt_a, 0);
    chk("ar.err_a", MDU_err_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It drives stall and flush controls into the PC, IF/ID and ID/EX registers, detects load-use hazards and squashes on taken branches or jumps. It also runs a start/done handshake with the multi-cycle multiply/divide unit (MDU), with a watchdog. All state advances on posedge CLK; control outputs are combinational from state and current inputs, so they are settled before the pipeline registers capture.

Parameters:
RADDR_W, 6, register-address width (matches Rd width in pipeline registers)
MDU_TIMEOUT, 64, max MDU_WAIT cycles before watchdog abort
CNT_W, 32, stall performance-counter width

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  asynchronous, active-high reset
rs1_ID  in  RADDR_W  rs1 address of instruction in ID
rs2_ID  in  RADDR_W  rs2 address of instruction in ID
rs1_used_ID  in  1  ID instruction reads rs1
rs2_used_ID  in  1  ID instruction reads rs2
MDU_req_ID  in  1  ID instruction needs MDU
Rd_EX  in  RADDR_W  destination of instruction in EX
RegWr_EX  in  1  EX instruction writes a register
MemtoReg_EX  in  1  EX instruction is a load
Taken_EX  in  1  branch taken or jump resolved in EX
MDU_done  in  1  MDU result valid, one-cycle pulse
PC_stall  out  1  hold PC
IF_ID_stall  out  1  hold IF/ID
IF_ID_flush  out  1  clear IF/ID to NOP
ID_EX_flush  out  1  load bubble (all control zero) into ID/EX
MDU_start  out  1  one-cycle MDU launch pulse
MDU_err  out  1  sticky watchdog-abort flag
Stall_cnt  out  CNT_W  cycles with PC_stall=1, saturating

Behaviour:
- Reset (async, active-high): state=RUN, wait counter=0, MDU_err=0, Stall_cnt=0. All outputs 0 while Reset=1. Reset mid-MDU_WAIT abandons the operation and issues no further MDU_start.
- lu_hz = MemtoReg_EX & RegWr_EX & (Rd_EX!=0) & ((rs1_used_ID & rs1_ID==Rd_EX) | (rs2_used_ID & rs2_ID==Rd_EX)).
- States: RUN, MDU_WAIT.
- RUN, priority order:
  1. Taken_EX: IF_ID_flush=1 and ID_EX_flush=1; no stall; no MDU_start even if MDU_req_ID (instruction is squashed); stay RUN.
  2. lu_hz: PC_stall=IF_ID_stall=ID_EX_flush=1 for exactly that cycle; stay RUN. The hazard clears once the bubble occupies EX, giving 1 bubble per load-use.
  3. MDU_req_ID: MDU_start=1, PC_stall=IF_ID_stall=ID_EX_flush=1, wait counter cleared; go to MDU_WAIT.
  4. Otherwise all controls 0.
- MDU_WAIT: EX holds only bubbles, so Taken_EX is ignored. lu_hz cannot arise.
  - MDU_done=0: PC_stall=IF_ID_stall=ID_EX_flush=1; wait counter +1.
  - MDU_done=1: all controls 0, so the MDU instruction advances into ID/EX this cycle; go to RUN.
  - Wait counter reaches MDU_TIMEOUT-1 without done: set MDU_err (sticky until Reset); release stall as in the done case; go to RUN.
  - MDU_start is never asserted in MDU_WAIT.
- MDU_done arriving in RUN is ignored.
- Stall_cnt increments on every rising edge where PC_stall=1; it holds at all-ones.
- Register x0 (Rd_EX=0) never causes a hazard.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - RADDR_W
  - state encoding localparams ST_RUN=1'b0, ST_MDU_WAIT=1'b1
  - NOP/bubble constant used by the pipeline registers
- One sub-module, hazard_cmp: purely combinational lu_hz detection, reused later for forwarding-select logic.

Test Plan:
- Load-use: EX load Rd_EX=5, RegWr/MemtoReg=1, ID rs1_ID=5 used -> exactly 1 cycle of PC_stall/IF_ID_stall/ID_EX_flush=1, then 0; Stall_cnt=1.
- x0 and unused source: Rd_EX=0 with rs1_ID=0, or rs2_ID match with rs2_used_ID=0 -> no stall.
- Branch flush priority: Taken_EX=1 with lu_hz=1 and MDU_req_ID=1 in the same cycle -> IF_ID_flush=ID_EX_flush=1, PC_stall=0, MDU_start=0, state stays RUN.
- MDU handshake: MDU_req_ID=1 -> MDU_start for 1 cycle; MDU_done returned 10 cycles later -> stall held 11 cycles total, released the done cycle; Stall_cnt=11.
- Watchdog: MDU_TIMEOUT=8, MDU_done never returned -> stall released after 8 cycles, MDU_err=1 and stays 1 through a later normal MDU operation.
- Async reset mid-MDU_WAIT: pulse Reset between edges -> outputs 0 immediately; after release state=RUN and Stall_cnt=0; a stray MDU_done is ignored.
